// File: rtl/inst_fetch.sv
// DLX instruction fetch: owns the PC, fetches from a variable-latency memory and
// holds the instruction for decode/execute, then computes the next PC on retire.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [31:0]      instruction,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    output logic [31:0]      link_addr,
    input  logic             branch,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic             rs1_zero,
    input  logic [31:0]      reg_target,
    input  logic             hold,
    output logic             fault,
    output logic [CNT_W-1:0] retire_count
);

    // state | meaning
    // IDLE  | one-cycle settle after reset
    // FETCH | request outstanding at pc, waiting for imem_valid
    // EXEC  | instruction live; retires on the first cycle without hold
    // FAULT | misaligned next PC seen; only reset leaves
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] jmp_off;
    logic [31:0] br_off;
    logic        br_taken;
    logic [31:0] next_pc;

    always_comb begin
        p4       = instr_pc + 32'd4;
        jmp_off  = {{6{instruction[25]}}, instruction[25:0]};
        br_off   = {{16{instruction[15]}}, instruction[15:0]};
        // instruction[26] distinguishes BNEZ (1) from BEQZ (0)
        br_taken = instruction[26] ? ~rs1_zero : rs1_zero;
        next_pc  = p4;
        if (jump_reg) begin
            next_pc = reg_target;
        end else if (jump) begin
            next_pc = p4 + jmp_off;
        end else if (branch && br_taken) begin
            next_pc = p4 + br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instruction  <= 32'h0;
            instr_pc     <= 32'h0;
            retire_count <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        instr_pc    <= pc;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!hold) begin
                        retire_count <= retire_count + CNT_W'(1);
                        pc           <= next_pc;
                        state        <= (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
                    end
                end
                default: state <= FAULT;
            endcase
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign fault       = (state == FAULT);
    assign link_addr   = p4;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, reset/fault sequences and a
// randomized instruction stream checked against a transaction-level PC model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] link_addr;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        rs1_zero = 1'b0;
    logic [31:0] reg_target = 32'h0;
    logic        hold = 1'b0;
    logic        fault;
    logic [31:0] retire_count;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic        exp_fault;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .link_addr(link_addr),
        .branch(branch), .jump(jump), .jump_reg(jump_reg),
        .rs1_zero(rs1_zero), .reg_target(reg_target), .hold(hold),
        .fault(fault), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] w;
        int          lat;
        int          holds;
        logic        br, jp, jr, rz;
        logic [31:0] tgt;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Controls are only meaningful in a non-held EXEC cycle; drive noise elsewhere.
    task automatic scramble();
        branch     = 1'($urandom);
        jump       = 1'($urandom);
        jump_reg   = 1'($urandom);
        rs1_zero   = 1'($urandom);
        reg_target = $urandom;
        hold       = 1'($urandom);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic [31:0] w,
                                               input logic br, input logic jp, input logic jr,
                                               input logic rz, input logic [31:0] tgt);
        logic [31:0] base;
        int          off;
        logic        is_bnez;
        base    = ipc + 32'd4;
        is_bnez = w[26];
        if (jr) return tgt;
        if (jp) begin
            off = $signed(w[25:0]);
            return base + 32'(off);
        end
        if (br && ((is_bnez && !rz) || (!is_bnez && rz))) begin
            off = $signed(w[15:0]);
            return base + 32'(off);
        end
        return base;
    endfunction

    task automatic reset_dut();
        imem_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        exp_fault = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] w, input int lat, input int holds,
                            input logic br, input logic jp, input logic jr, input logic rz,
                            input logic [31:0] tgt, input logic [31:0] nxt);
        int n;
        logic [31:0] lk;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            scramble();
            tick();
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int k = 1; k <= lat; k++) begin
            scramble();
            tick();
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, exp_pc);
            chk("no_early_valid", 32'(instr_valid), 32'd0);
            if (k == lat) begin
                imem_valid = 1'b1;
                imem_rdata = w;
            end
        end
        tick();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        lk = exp_pc + 32'd4;
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("instruction", instruction, w);
        chk("instr_pc", instr_pc, exp_pc);
        chk("link_addr", link_addr, lk);
        chk("req_drop", 32'(imem_req), 32'd0);
        chk("count_pre", retire_count, exp_count);
        for (int h = 0; h < holds; h++) begin
            scramble();
            hold = 1'b1;
            tick();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instruction, w);
            chk("hold_pc", instr_pc, exp_pc);
            chk("hold_count", retire_count, exp_count);
            chk("hold_noreq", 32'(imem_req), 32'd0);
        end
        hold = 1'b0; branch = br; jump = jp; jump_reg = jr; rs1_zero = rz; reg_target = tgt;
        tick();
        exp_count = exp_count + 32'd1;
        exp_pc    = nxt;
        chk("retire_count", retire_count, exp_count);
        if (nxt[1:0] != 2'b00) begin
            exp_fault = 1'b1;
            chk("fault_set", 32'(fault), 32'd1);
            chk("fault_noreq", 32'(imem_req), 32'd0);
            chk("fault_novalid", 32'(instr_valid), 32'd0);
        end else begin
            chk("next_req", 32'(imem_req), 32'd1);
            chk("next_addr", imem_addr, nxt);
            chk("no_fault", 32'(fault), 32'd0);
        end
        scramble();
    endtask

    task automatic fault_hold();
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'($urandom);
            imem_rdata = $urandom;
            scramble();
            tick();
            chk("fault_sticky", 32'(fault), 32'd1);
            chk("fault_req_off", 32'(imem_req), 32'd0);
            chk("fault_invalid", 32'(instr_valid), 32'd0);
        end
        imem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w, tgt, nxt;
        logic        br, jp, jr, rz;
        int          lat, holds;

        tbl[0]  = '{32'h2022_0820, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0004};
        tbl[1]  = '{32'h1234_5678, 5, 0, 0, 0, 1, 0, 32'h100,       32'h0000_0100};
        tbl[2]  = '{32'h1000_FFF0, 1, 0, 1, 0, 0, 1, 32'h0,         32'h0000_00F4};
        tbl[3]  = '{32'h0000_0000, 2, 0, 0, 0, 1, 0, 32'h100,       32'h0000_0100};
        tbl[4]  = '{32'h1400_FFF0, 1, 0, 1, 0, 0, 1, 32'h0,         32'h0000_0104};
        tbl[5]  = '{32'h0BAD_CAFC, 1, 0, 1, 1, 1, 0, 32'h2000,      32'h0000_2000};
        tbl[6]  = '{32'hAAAA_5554, 3, 0, 0, 0, 1, 0, 32'h40,        32'h0000_0040};
        tbl[7]  = '{32'h0800_0010, 1, 0, 0, 1, 0, 0, 32'h0,         32'h0000_0054};
        tbl[8]  = '{32'h5555_AAA8, 1, 3, 0, 0, 0, 0, 32'h0,         32'h0000_0058};
        tbl[9]  = '{32'h0000_0000, 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[10] = '{32'h0C00_1000, 2, 1, 0, 0, 0, 1, 32'h0,         32'h0000_0000};
        tbl[11] = '{32'h0000_0000, 1, 0, 0, 0, 1, 0, 32'h2002,      32'h0000_2002};

        reset_dut();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_link", link_addr, 32'd4);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", retire_count, 32'h0);

        for (int i = 0; i < 12; i++) begin
            do_instr(tbl[i].w, tbl[i].lat, tbl[i].holds, tbl[i].br, tbl[i].jp,
                     tbl[i].jr, tbl[i].rz, tbl[i].tgt, tbl[i].exp_next);
        end
        fault_hold();

        // Reset release, stray imem_valid in IDLE, then reset mid-fetch.
        reset_dut();
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0;
        chk("idle_valid_ignored", 32'(instr_valid), 32'd0);
        chk("idle_instr_kept", instruction, 32'h0);
        chk("fetch_after_idle", 32'(imem_req), 32'd1);
        tick();
        tick();
        chk("fetch_wait_req", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req), 32'd0);
        chk("async_count", retire_count, 32'h0);
        tick();
        rst_n = 1'b1;
        exp_pc = 32'h0; exp_count = 32'h0; exp_fault = 1'b0;

        for (int i = 0; i < 200; i++) begin
            w = $urandom;
            if ($urandom_range(7) != 0) w[1:0] = 2'b00;
            tgt = $urandom;
            if ($urandom_range(7) != 0) tgt[1:0] = 2'b00;
            jr    = ($urandom_range(9) == 0);
            jp    = ($urandom_range(5) == 0);
            br    = 1'($urandom);
            rz    = 1'($urandom);
            lat   = $urandom_range(4, 1);
            holds = ($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0;
            nxt   = model_next(exp_pc, w, br, jp, jr, rz, tgt);
            do_instr(w, lat, holds, br, jp, jr, rz, tgt, nxt);
            if (exp_fault) begin
                fault_hold();
                reset_dut();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
